aes_host_driver: RTL and testbench

Host-side master for the byte-serial AES core port (din/cmd/ready in, dout/ok out). It takes a 128-bit plaintext and key in one request, serializes them as key and plaintext bytes, and issues the start command. It then captures the 16 ciphertext bytes back into a 128-bit word. It sits between a wide host register interface and the AES top, and drives the opposite end of the core's byte protocol.

---
 rtl/aes_host_driver.sv | 111 +++++++++++
 tb/tb_aes_host_driver.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/aes_host_driver.sv
// aes_host_driver: loads a 128-bit key/plaintext into the byte-serial AES core (din/cmd/ready), then collects 16 ciphertext bytes (dout/ok) into cipher_out
module aes_host_driver #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         req,
  input  logic [127:0] plain_in,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [127:0] cipher_out,
  output logic [7:0]   din,
  output logic [1:0]   cmd,
  input  logic         ready,
  input  logic [7:0]   dout,
  input  logic         ok
);
  typedef enum logic [2:0] {IDLE, SEND_KEY, SEND_PT, SEND_GO, WAIT_OK, COLLECT, DONE, ERR} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [15:0] tcnt;
  logic [119:0] key_sr;
  logic [127:0] pt_sr;
  logic [119:0] ct_sr;
  always_ff @(posedge clk) begin
    if (rst_) begin
      state <= IDLE;
      cnt <= '0;
      tcnt <= '0;
      key_sr <= '0;
      pt_sr <= '0;
      ct_sr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      cipher_out <= '0;
      din <= '0;
      cmd <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          key_sr <= key_in[119:0];
          pt_sr <= plain_in;
          cnt <= '0;
          busy <= 1'b1;
          cmd <= 2'b01;
          din <= key_in[127:120];
          state <= SEND_KEY;
        end
        SEND_KEY: if (ready) begin
          if (cnt == 4'd15) begin
            cnt <= '0;
            cmd <= 2'b10;
            din <= pt_sr[127:120];
            state <= SEND_PT;
          end else begin
            cnt <= cnt + 4'd1;
            din <= key_sr[119:112];
            key_sr <= {key_sr[111:0], 8'h00};
          end
        end
        SEND_PT: if (ready) begin
          if (cnt == 4'd15) begin
            cnt <= '0;
            cmd <= 2'b11;
            din <= '0;
            state <= SEND_GO;
          end else begin
            cnt <= cnt + 4'd1;
            din <= pt_sr[119:112];
            pt_sr <= {pt_sr[119:0], 8'h00};
          end
        end
        SEND_GO: if (ready) begin
          cmd <= '0;
          tcnt <= '0;
          state <= WAIT_OK;
        end
        WAIT_OK: if (ok) begin
          ct_sr <= {112'd0, dout};
          cnt <= 4'd1;
          state <= COLLECT;
        end else if (tcnt == 16'(TIMEOUT)) begin
          err <= 1'b1;
          state <= ERR;
        end else begin
          tcnt <= tcnt + 16'd1;
        end
        COLLECT: if (!ok) begin
          err <= 1'b1;
          state <= ERR;
        end else if (cnt == 4'd15) begin
          cipher_out <= {ct_sr, dout};
          done <= 1'b1;
          state <= DONE;
        end else begin
          ct_sr <= {ct_sr[111:0], dout};
          cnt <= cnt + 4'd1;
        end
        DONE, ERR: begin
          done <= 1'b0;
          err <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_host_driver.sv
// tb_aes_host_driver: randomized core-side model checking byte order, stalls, latency, capture, timeout and reset
module tb_aes_host_driver;
  logic clk = 1'b0;
  logic rst_ = 1'b1;
  logic req = 1'b0;
  logic ready = 1'b0;
  logic ok = 1'b0;
  logic [127:0] plain_in = '0;
  logic [127:0] key_in = '0;
  logic [7:0] dout = '0;
  logic busy, done, err;
  logic [127:0] cipher_out;
  logic [7:0] din;
  logic [1:0] cmd;
  int checks = 0;
  int failures = 0;
  logic [127:0] last_cipher = '0;
  aes_host_driver #(.TIMEOUT(8)) dut (
    .clk(clk), .rst_(rst_), .req(req), .plain_in(plain_in), .key_in(key_in),
    .busy(busy), .done(done), .err(err), .cipher_out(cipher_out),
    .din(din), .cmd(cmd), .ready(ready), .dout(dout), .ok(ok)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  // drop: 0 = ok never rises (timeout), 1..15 = ok falls after that many bytes, 16 = full response
  task automatic txn(input logic [127:0] k, input logic [127:0] p, input logic [127:0] c,
                     input int stall_pct, input logic [63:0] smask, input int drop,
                     input bit noise, input int exp_go);
    logic [127:0] kq = '0;
    logic [127:0] pq = '0;
    int nk = 0, np = 0, cyc = 1, stalls = 0, go = -1;
    logic [1:0] pc = '0;
    logic [7:0] pd = '0;
    bit pr = 1'b1;
    bit dropped = 1'b0;
    key_in = k;
    plain_in = p;
    req = 1'b1;
    step;
    req = 1'b0;
    check("busy_rise", busy, 1);
    while (go < 0 && cyc < 300) begin
      if (!pr) begin
        check("stall_cmd", cmd, pc);
        check("stall_din", din, pd);
      end
      check("cmd_seq", cmd, nk < 16 ? 2'b01 : np < 16 ? 2'b10 : 2'b11);
      ready = !smask[cyc[5:0]] && ($urandom_range(99) >= stall_pct);
      ok = noise && $urandom_range(1) == 1;
      dout = 8'($urandom);
      req = noise && $urandom_range(1) == 1;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      plain_in = {$urandom, $urandom, $urandom, $urandom};
      if (!ready) stalls++;
      else if (cmd == 2'b01) begin kq = {kq[119:0], din}; nk++; end
      else if (cmd == 2'b10) begin pq = {pq[119:0], din}; np++; end
      else if (cmd == 2'b11) go = cyc;
      pc = cmd;
      pd = din;
      pr = ready;
      step;
      cyc++;
    end
    req = 1'b0;
    ok = 1'b0;
    ready = 1'b1;
    check("go_cycle", go, 33 + stalls);
    if (exp_go > 0) check("go_cycle_fixed", go, exp_go);
    check("key_bytes", kq, k);
    check("plain_bytes", pq, p);
    check("wait_cmd", cmd, 0);
    if (drop == 0) begin
      for (int i = 0; i < 9; i++) begin
        check("no_early_err", err, 0);
        step;
      end
      check("timeout_err", err, 1);
      check("timeout_cipher", cipher_out, last_cipher);
      step;
      check("timeout_busy", busy, 0);
      return;
    end
    repeat ($urandom_range(3)) step;
    for (int i = 0; i < 16; i++) begin
      if (i == drop) begin dropped = 1'b1; break; end
      ok = 1'b1;
      dout = c[127 - 8*i -: 8];
      step;
    end
    ok = 1'b0;
    if (dropped) begin
      step;
      check("drop_err", err, 1);
      check("drop_done", done, 0);
      check("drop_cipher", cipher_out, last_cipher);
    end else begin
      check("done_pulse", done, 1);
      check("done_err", err, 0);
      check("cipher", cipher_out, c);
      check("done_busy", busy, 1);
      last_cipher = c;
    end
    step;
    check("end_busy", busy, 0);
    check("end_done", done | err, 0);
  endtask
  initial begin
    logic [63:0] fips_mask;
    fips_mask = '0;
    fips_mask[5] = 1'b1;
    fips_mask[6] = 1'b1;
    fips_mask[20] = 1'b1;
    step;
    step;
    rst_ = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_flags", {done, err}, 0);
    check("rst_cipher", cipher_out, 0);
    check("rst_cmd_din", {cmd, din}, 0);
    txn(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
        128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, '0, 16, 1'b0, 33);
    txn(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
        128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, fips_mask, 16, 1'b0, 36);
    txn({4{$urandom}}, {4{$urandom}}, {4{$urandom}}, 20, '0, 10, 1'b0, 0);
    txn({4{$urandom}}, {4{$urandom}}, {4{$urandom}}, 20, '0, 0, 1'b0, 0);
    txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
        {$urandom, $urandom, $urandom, $urandom}, 25, '0, 16, 1'b1, 0);
    for (int t = 0; t < 6; t++)
      txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
          {$urandom, $urandom, $urandom, $urandom}, 30, '0, t == 3 ? 5 : 16, t[0], 0);
    key_in = {$urandom, $urandom, $urandom, $urandom};
    plain_in = {$urandom, $urandom, $urandom, $urandom};
    req = 1'b1;
    ready = 1'b1;
    step;
    req = 1'b0;
    repeat (19) step;
    check("pre_rst_cmd", cmd, 2'b10);
    rst_ = 1'b1;
    step;
    rst_ = 1'b0;
    check("mid_rst_cmd", cmd, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_cipher", cipher_out, 0);
    last_cipher = '0;
    step;
    txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
        {$urandom, $urandom, $urandom, $urandom}, 10, '0, 16, 1'b0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
